tt_um_example_spi_pwm: RTL and testbench
========================================

// Module: tt_um_example_spi_pwm
// PURPOSE
// - Top-level tile: SPI-mode-0 write peripheral holding 5 config registers that drive 16 outputs.
// - Each output is either a static level or a shared 8-bit PWM waveform.
// - Sits directly on the standard tile pin interface.
// - ena is ignored; the design always runs.
// PARAMETERS
// - CLK_DIV  default 13  clk cycles per PWM counter step (PWM period = 256*CLK_DIV clk)
// PORTS
// - clk      in   1  system clock, all logic on rising edge
// - rst_n    in   1  synchronous reset, active-HIGH (1 = reset); name kept for pin-list compatibility
// - ena      in   1  tile enable, unused
// - ui_in    in   8  [0]=SCLK, [1]=COPI, [2]=nCS (active low); [7:3] unused
// - uo_out   out  8  output bank A
// - uio_in   in   8  unused
// - uio_out  out  8  output bank B
// - uio_oe   out  8  constant 8'hFF (all uio pins are outputs)
// BEHAVIOUR
// - Input sync: SCLK, COPI and nCS each pass through a 2-FF synchronizer.
//   - SCLK rise/fall and nCS rise/fall are detected from the synced signals.
// - SPI frame: nCS falling edge clears the bit counter and shift register.
//   - While nCS=0, every SCLK rising edge shifts COPI in, MSB first.
//   - Frame = 16 bits: [15] R/W (1 = write), [14:8] address, [7:0] data.
// - Commit: on nCS rising edge, only if exactly 16 bits were received and bit15=1.
//   - Address 0x00..0x04: data is written to that register.
//   - Address >= 0x05: the frame is discarded.
//   - Frames with <16 or >16 bits are discarded; registers are unchanged.
// - Registers (all reset to 8'h00):
//   - 0x00 en_uo: static enable for uo_out
//   - 0x01 en_uio: static enable for uio_out
//   - 0x02 pwm_uo: PWM select for uo_out
//   - 0x03 pwm_uio: PWM select for uio_out
//   - 0x04 duty: PWM duty
// - PWM: 8-bit counter cnt advances by 1 every CLK_DIV clk and wraps 255 -> 0.
//   - pwm = (duty==8'hFF) ? 1 : (cnt < duty).
//   - duty=0 gives pwm always 0.
// - Output bit i: uo_out[i] = en_uo[i] & (pwm_uo[i] ? pwm : 1). uio_out is built the same way.
// - Latency: new register value reaches the outputs no later than 4 clk after nCS rises at the pin.
// - Reset: all registers, cnt, prescaler, the bit counter and shift register clear to 0.
//   - Reset dominates any SPI activity in the same cycle.
//   - Reset mid-frame discards the frame.
//   - After reset: uo_out=0, uio_out=0, uio_oe=8'hFF.
// - All state (registers and PWM counter) is held while nCS=1.
// CONFIGURATION
// - Macro SPI_READBACK_EN defined:
//   - Frame with bit15=0 is a read. CIPO is driven on uio_out[7], MSB first, on each SCLK falling edge.
//   - During bits 7..0 CIPO carries register[address]; it is 0 for invalid addresses and 0 elsewhere in the frame.
//   - uio_out[7] shows CIPO while nCS=0 during a read. Otherwise it shows its normal register-driven value.
// - Macro SPI_READBACK_EN undefined: read frames are ignored and uio_out[7] is always register-driven.
// TESTING
// - Reset 2 clk: uo_out=00, uio_out=00, uio_oe=FF.
// - Write 0x00<-0xF0 (frame 0x80F0): uo_out=F0 within 4 clk of nCS rise.
// - Write 0x01<-0xFF, 0x03<-0x01, 0x04<-0x80: uio_out[0] high 128 of 256 steps.
//   - Period = 256*CLK_DIV clk. uio_out[7:1]=7F static.
// - duty=00 gives uio_out[0] constantly 0. duty=FF gives it constantly 1 over 2 full periods.
// - Rejected frames leave outputs unchanged:
//   - frame to address 0x05
//   - 15-bit frame
//   - 17-bit frame
//   - read frame 0x0000
// - nCS raised after 8 bits, then a new full write 0x8055: only the second frame takes effect (uo_out=55).
// - With SPI_READBACK_EN: after uo_out=55, read frame 0x0000 returns 0x55 on uio_out[7], bits 7..0.

Source files
------------

// File: rtl/tt_um_example_spi_pwm.sv
// tt_um_example_spi_pwm: SPI mode-0 write peripheral with five config registers
// driving two 8-bit output banks as static levels or a shared 8-bit PWM.
// Optional feature macro: SPI_READBACK_EN (read frames return register data
// on uio_out[7], MSB first, during the data byte).
module tt_um_example_spi_pwm #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic        unused_ok;
  logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic        sclk_prev_q, sclk_prev_d, ncs_prev_q, ncs_prev_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  regs_q [5];
  logic [7:0]  regs_d [5];
  logic [15:0] pre_q, pre_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        sclk_s, copi_s, ncs_s;
  logic        sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  logic        pwm;
  logic [7:0]  uio_norm;
`ifdef SPI_READBACK_EN
  logic        rd_active_q, rd_active_d, cipo_q, cipo_d;
  logic [7:0]  rd_byte_q, rd_byte_d, rd_val;
`endif

  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};

  // Next-state logic: synchronizers, SPI shifter, register commit, PWM counter
  always_comb begin
    sync1_d     = {ui_in[2], ui_in[1], ui_in[0]};
    sync2_d     = sync1_q;
    sclk_s      = sync2_q[0];
    copi_s      = sync2_q[1];
    ncs_s       = sync2_q[2];
    sclk_prev_d = sclk_s;
    ncs_prev_d  = ncs_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    ncs_rise    = ncs_s & ~ncs_prev_q;
    ncs_fall    = ~ncs_s & ncs_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;

    if (ncs_fall) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (!ncs_s && sclk_rise) begin
      shift_d = {shift_q[14:0], copi_s};
      // Saturate so long frames never alias back to a 16-bit count
      if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 5'd1;
    end

    if (ncs_rise && bit_cnt_q == 5'd16 && shift_q[15] && shift_q[14:8] < 7'd5)
      regs_d[shift_q[10:8]] = shift_q[7:0];

    // PWM timebase only advances while the bus is selected
    if (!ncs_s) begin
      if (pre_q == 16'(CLK_DIV - 1)) begin
        pre_d = '0;
        cnt_d = cnt_q + 8'd1;
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end

`ifdef SPI_READBACK_EN
    rd_active_d = rd_active_q;
    cipo_d      = cipo_q;
    rd_byte_d   = rd_byte_q;
    rd_val      = '0;
    if (ncs_fall) begin
      rd_active_d = 1'b0;
      cipo_d      = 1'b0;
      rd_byte_d   = '0;
    end else if (!ncs_s && sclk_rise && bit_cnt_q == 5'd0) begin
      rd_active_d = ~copi_s;
    end else if (!ncs_s && sclk_fall) begin
      if (bit_cnt_q == 5'd8) begin
        // shift_q[6:0] holds the address once the header byte is in
        if (shift_q[6:0] < 7'd5) rd_val = regs_q[shift_q[2:0]];
        cipo_d    = rd_val[7];
        rd_byte_d = {rd_val[6:0], 1'b0};
      end else if (bit_cnt_q > 5'd8 && bit_cnt_q < 5'd16) begin
        cipo_d    = rd_byte_q[7];
        rd_byte_d = {rd_byte_q[6:0], 1'b0};
      end else begin
        cipo_d = 1'b0;
      end
    end
`endif
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1_q     <= 3'b100;
      sync2_q     <= 3'b100;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      regs_q      <= '{default: '0};
      pre_q       <= '0;
      cnt_q       <= '0;
`ifdef SPI_READBACK_EN
      rd_active_q <= 1'b0;
      cipo_q      <= 1'b0;
      rd_byte_q   <= '0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sclk_prev_q <= sclk_prev_d;
      ncs_prev_q  <= ncs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      regs_q      <= regs_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
`ifdef SPI_READBACK_EN
      rd_active_q <= rd_active_d;
      cipo_q      <= cipo_d;
      rd_byte_q   <= rd_byte_d;
`endif
    end
  end

  // Output mapping: enable gates either a static high or the PWM waveform
  always_comb begin
    pwm      = (regs_q[4] == 8'hFF) ? 1'b1 : (cnt_q < regs_q[4]);
    uo_out   = regs_q[0] & (~regs_q[2] | {8{pwm}});
    uio_norm = regs_q[1] & (~regs_q[3] | {8{pwm}});
    uio_oe   = 8'hFF;
    uio_out  = uio_norm;
`ifdef SPI_READBACK_EN
    if (rd_active_q && !ncs_s) uio_out[7] = cipo_q;
`endif
  end

endmodule

// File: tb/tb_tt_um_example_spi_pwm.sv
// Scoreboard bench for tt_um_example_spi_pwm: SPI writes, rejected frames,
// PWM duty measurement and (with SPI_READBACK_EN) register readback.
module tb_tt_um_example_spi_pwm;

  localparam int unsigned CLK_DIV = 13;
  localparam int unsigned PERIOD  = 256 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_in, uio_out, uio_oe;

  assign ui_in  = {5'b0, ncs, copi, sclk};
  assign uio_in = 8'h00;

  tt_um_example_spi_pwm #(.CLK_DIV(CLK_DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
    logic [15:0] mask;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_expect(input string tag, input logic [15:0] exp, input logic [15:0] mask);
    exp_t e;
    e.tag = tag; e.exp = exp; e.mask = mask;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare {uio_out, uo_out} under its mask
  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, 32'({uio_out, uo_out} & e.mask), 32'(e.exp & e.mask));
    end
  endtask

  // Mode-0 master: COPI set while SCLK low, CIPO sampled just before each rise
  task automatic send_frame(input logic [31:0] bits, input int n, output logic [31:0] miso);
    miso = '0;
    ncs = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      tick(4);
      @(negedge clk);
      miso = {miso[30:0], uio_out[7]};
      @(posedge clk); #1;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    ncs  = 1'b1;
    copi = 1'b0;
  endtask

  task automatic frame_expect(input string tag, input logic [31:0] bits, input int n,
                              input logic [15:0] exp, input logic [15:0] mask);
    logic [31:0] miso;
    sb_expect(tag, exp, mask);
    send_frame(bits, n, miso);
    tick(4);
    @(negedge clk);
    sb_compare();
  endtask

  // Hold nCS low with SCLK idle so the PWM timebase runs, count uio_out[0] highs
  task automatic measure(input int cycles, output int highs, output int bad);
    highs = 0;
    bad   = 0;
    ncs = 1'b0;
    tick(6);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (uio_out[0]) highs++;
      if (uio_out[7:1] != 7'h7F) bad++;
    end
    @(posedge clk); #1;
    ncs = 1'b1;
    tick(4);
  endtask

  initial begin
    int          highs, bad;
    logic [31:0] miso;

    tick(2);
    @(negedge clk);
    check("rst_uo", 32'(uo_out), 32'h00);
    check("rst_uio", 32'(uio_out), 32'h00);
    check("rst_oe", 32'(uio_oe), 32'hFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    tick(2);

    frame_expect("wr_en_uo", 32'h80F0, 16, 16'h00F0, 16'hFFFF);
    frame_expect("wr_en_uio", 32'h81FF, 16, 16'hFFF0, 16'hFFFF);
    frame_expect("wr_pwm_uio", 32'h8301, 16, 16'hFEF0, 16'hFFFF);
    frame_expect("wr_duty80", 32'h8480, 16, 16'hFEF0, 16'hFEFF);

    measure(PERIOD, highs, bad);
    check("pwm80_high", 32'(highs), 32'(128 * CLK_DIV));
    check("pwm80_static", 32'(bad), 32'd0);

    frame_expect("wr_duty00", 32'h8400, 16, 16'hFEF0, 16'hFFFF);
    measure(PERIOD, highs, bad);
    check("pwm00_high", 32'(highs), 32'd0);

    frame_expect("wr_dutyFF", 32'h84FF, 16, 16'hFFF0, 16'hFFFF);
    measure(2 * PERIOD, highs, bad);
    check("pwmFF_high", 32'(highs), 32'(2 * PERIOD));
    check("pwmFF_static", 32'(bad), 32'd0);

    frame_expect("rej_addr5", 32'h8577, 16, 16'hFFF0, 16'hFFFF);
    frame_expect("rej_15bit", 32'h4078, 15, 16'hFFF0, 16'hFFFF);
    frame_expect("rej_17bit", 32'h100AA, 17, 16'hFFF0, 16'hFFFF);
    frame_expect("rej_read", 32'h0000, 16, 16'hFFF0, 16'hFFFF);
    frame_expect("rej_8bit", 32'h80, 8, 16'hFFF0, 16'hFFFF);
    frame_expect("wr_55", 32'h8055, 16, 16'hFF55, 16'hFFFF);

`ifdef SPI_READBACK_EN
    sb_expect("rb_after", 16'hFF55, 16'hFFFF);
    send_frame(32'h0000, 16, miso);
    check("rb_hdr_zero", 32'(miso[14:8]), 32'h00);
    check("rb_data", 32'(miso[7:0]), 32'h55);
    tick(4);
    @(negedge clk);
    sb_compare();
`endif

    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst2_uo", 32'(uo_out), 32'h00);
    check("rst2_uio", 32'(uio_out), 32'h00);
    check("rst2_oe", 32'(uio_oe), 32'hFF);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
